// File: rtl/dm_wait_slave_if.sv
// Request/acknowledge bus between the MEM stage (master) and the wait-state data memory (slave).
interface dm_wait_slave_if #(
    parameter int ADDR_W = 12
) ();
    logic              req;
    logic [5:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ack;
    logic              busy;
    logic              err;

    modport master (output req, op, addr, wdata, input rdata, ack, busy, err);
    modport slave  (input req, op, addr, wdata, output rdata, ack, busy, err);
endinterface

// File: rtl/dm_wait_slave.sv
// Word-organised data memory with a fixed number of wait states and internal byte/halfword lanes.
// Optional DM_MISALIGN_TRAP_EN: misaligned halfword/word accesses complete with err instead of being aligned.
module dm_wait_slave #(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    dm_wait_slave_if.slave  bus
);
    localparam int DEPTH = (2 ** ADDR_W) / 4;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    localparam logic [5:0] OP_LB  = 6'h20, OP_LH  = 6'h21, OP_LW = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24, OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28, OP_SH  = 6'h29, OP_SW = 6'h2B;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    state_t            state, state_next;
    logic [3:0]        cnt, cnt_next;
    logic [5:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic [31:0]       mem [DEPTH];

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            S_IDLE: if (bus.req) begin
                cnt_next   = WAIT_INIT;
                state_next = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
            end
            S_WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) state_next = S_RESP;
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // With zero wait states RESP is entered on the acceptance edge, so the live bus is used there.
    logic [5:0]        acc_op;
    logic [ADDR_W-1:0] acc_addr;
    logic [31:0]       acc_wdata;
    assign acc_op    = (state == S_IDLE) ? bus.op    : op_q;
    assign acc_addr  = (state == S_IDLE) ? bus.addr  : addr_q;
    assign acc_wdata = (state == S_IDLE) ? bus.wdata : wdata_q;

    logic              is_valid, is_load, is_store, is_signed, misalign, acc_err;
    size_t             size;
    logic [ADDR_W-1:0] eff_addr;

    always_comb begin
        is_valid  = 1'b1;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_signed = 1'b0;
        size      = SZ_W;
        case (acc_op)
            OP_LB:   begin is_load  = 1'b1; size = SZ_B; is_signed = 1'b1; end
            OP_LH:   begin is_load  = 1'b1; size = SZ_H; is_signed = 1'b1; end
            OP_LW:   begin is_load  = 1'b1; size = SZ_W; end
            OP_LBU:  begin is_load  = 1'b1; size = SZ_B; end
            OP_LHU:  begin is_load  = 1'b1; size = SZ_H; end
            OP_SB:   begin is_store = 1'b1; size = SZ_B; end
            OP_SH:   begin is_store = 1'b1; size = SZ_H; end
            OP_SW:   begin is_store = 1'b1; size = SZ_W; end
            default: is_valid = 1'b0;
        endcase

        eff_addr = acc_addr;
`ifdef DM_MISALIGN_TRAP_EN
        misalign = ((size == SZ_H) && acc_addr[0]) || ((size == SZ_W) && (acc_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
        if (size == SZ_H)      eff_addr[0]   = 1'b0;
        else if (size == SZ_W) eff_addr[1:0] = 2'b00;
`endif
        acc_err = !is_valid || misalign;
    end

    logic [ADDR_W-3:0] word_idx;
    logic [1:0]        lane;
    logic [31:0]       mem_word, wr_word, ld_word;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    assign word_idx = eff_addr[ADDR_W-1:2];
    assign lane     = eff_addr[1:0];
    assign mem_word = mem[word_idx];
    assign rd_byte  = mem_word[{lane, 3'b000} +: 8];
    assign rd_half  = mem_word[{lane[1], 4'b0000} +: 16];

    always_comb begin
        wr_word = mem_word;
        ld_word = mem_word;
        case (size)
            SZ_B: begin
                wr_word[{lane, 3'b000} +: 8] = acc_wdata[7:0];
                ld_word = {{24{is_signed & rd_byte[7]}}, rd_byte};
            end
            SZ_H: begin
                wr_word[{lane[1], 4'b0000} +: 16] = acc_wdata[15:0];
                ld_word = {{16{is_signed & rd_half[15]}}, rd_half};
            end
            default: wr_word = acc_wdata;
        endcase
    end

    logic enter_resp, do_write;
    assign enter_resp = (state_next == S_RESP) && (state != S_RESP);
    assign do_write   = enter_resp && is_store && !acc_err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            op_q    <= 6'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (state == S_IDLE && bus.req) begin
                op_q    <= bus.op;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
            end
            if (enter_resp) begin
                rdata_q <= (is_load && !acc_err) ? ld_word : 32'd0;
                err_q   <= acc_err;
            end else begin
                rdata_q <= 32'd0;
                err_q   <= 1'b0;
            end
        end
    end

    // NOTE: the array is deliberately left out of reset; only the write enable sees rst, so a reset wins over a commit.
    always_ff @(posedge clk) begin
        if (rst && do_write) mem[word_idx] <= wr_word;
    end

    assign bus.busy  = (state != S_IDLE);
    assign bus.ack   = (state == S_RESP);
    assign bus.rdata = rdata_q;
    assign bus.err   = err_q;
endmodule

// File: doc/dm_wait_slave.md
# dm_wait_slave

Word-organised data-memory responder for the pipelined MIPS core. It answers the load and store requests issued by the core's MEM stage over a request/acknowledge handshake, with a fixed number of wait states. Byte and halfword lanes are handled internally, so the core can be verified against a memory with realistic latency instead of a zero-wait array. It sits on the MEM-stage side of the core, one responder per data port.

## Interface
- `ADDR_W`, 12: byte-address width. Depth is 2^ADDR_W / 4 words.
- `WAIT_CYCLES`, 2: wait states inserted before `ack`. Legal range 0–15.
- Reset is synchronous, active-low.
- `clk`  input  1: rising-edge clock.
- `rst`  input  1: synchronous, active-low reset.
- `req`  input  1: request. The initiator holds it high until `ack`.
- `op`  input  6: MIPS primary opcode of the access.
- `addr`  input  ADDR_W: byte address.
- `wdata`  input  32: store data, right-justified.
- `rdata`  output  32: load result, extended per `op`. Valid only while `ack`=1.
- `ack`  output  1: one-cycle completion pulse.
- `busy`  output  1: transaction in progress.
- `err`  output  1: error flag, valid with `ack`.

## Operation
- Supported ops:
  - Loads: lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25.
  - Stores: sb 0x28, sh 0x29, sw 0x2B.
- Little-endian lanes: byte k of a word is at `addr[1:0]`=k, bits 8k+7:8k. A halfword at `addr[1]`=h uses bits 16h+15:16h.
- Loads:
  - lb and lh sign-extend; lbu and lhu zero-extend.
  - lw returns the whole word.
- Stores:
  - sb and sh modify only the addressed lanes.
  - sw writes the whole word.
- States:
  - IDLE: `busy`=0, `ack`=0.
    - `req`=1 latches `op`, `addr` and `wdata`, and loads the counter with `WAIT_CYCLES`.
    - Goes to WAIT if `WAIT_CYCLES`>0, otherwise to RESP.
  - WAIT: `busy`=1. The counter decrements each cycle. At counter=1 the next state is RESP.
  - RESP: `busy`=1, `ack`=1, `rdata` and `err` driven. Always returns to IDLE.
- The store commits on the clock edge that enters RESP. A load in RESP reads the array after any commit on that edge.
- Inputs are ignored outside IDLE. Changing inputs mid-transaction has no effect, because the values are latched.
- Unsupported `op`: the access completes normally with `err`=1, `rdata`=0, and no write.
- Array contents are not initialised and are not affected by reset.

## Timing
- Reset (`rst`=0 at a rising edge) gives state IDLE, `ack`=0, `busy`=0, `err`=0, `rdata`=0, counter=0.
- Reset mid-transaction: the transaction is abandoned and no `ack` is produced.
  - If reset coincides with the RESP-entry edge, reset wins and the store is not committed.
- Latency: `ack` is high in cycle N+WAIT_CYCLES+1, where N is the acceptance edge.
- Throughput: one transaction per WAIT_CYCLES+2 cycles.
  - RESP always returns to IDLE, so `req` held high after `ack` is taken as a new request one cycle later.
  - The initiator must drop `req` in the cycle after `ack` if it has no further request.
- `rdata` and `err` are registered. They return to 0 whenever `ack`=0.

## Configuration
- `DM_MISALIGN_TRAP_EN` defined:
  - An access is misaligned if it is a halfword with `addr[0]`=1, or a word with `addr[1:0]`≠0.
  - A misaligned access completes with `err`=1, `rdata`=0, and no write.
- Not defined:
  - Misaligned low address bits are forced to alignment: `addr[0]` is cleared for halfwords, `addr[1:0]` for words.
  - The access proceeds normally and `err` is 0 for every supported op.

## Test plan
- Reset, then sw 0x2B, addr 0x010, wdata 0xDEADBEEF, then lw 0x23, addr 0x010:
  - Each `ack` arrives 3 cycles after acceptance with `WAIT_CYCLES`=2.
  - lw returns 0xDEADBEEF, `err`=0.
- Byte lanes:
  - After sb addr 0x011, wdata 0x000000A5, lw 0x010 returns 0xDEADA5EF.
  - lb 0x011 returns 0xFFFFFFA5; lbu 0x011 returns 0x000000A5.
- Halfwords: sh addr 0x012, wdata 0x00008001, then:
  - lh 0x012 returns 0xFFFF8001.
  - lhu 0x012 returns 0x00008001.
  - lw 0x010 returns 0x8001A5EF.
- Misaligned: lw addr 0x013 with memory word 0x010 = 0x8001A5EF.
  - With the macro: `err`=1, `rdata`=0.
  - Without the macro: `rdata`=0x8001A5EF, `err`=0.
- Reset abort: sw addr 0x020, wdata 0x12345678, with `rst`=0 pulsed in the WAIT state.
  - No `ack` is produced.
  - A later lw 0x020 does not return 0x12345678, given a prior sw 0x020 of 0.
- Edge cases:
  - With `WAIT_CYCLES`=0: `ack` arrives one cycle after acceptance. `req` held high gives `ack` pulses every 2 cycles.
  - Unsupported op 0x0F: `err`=1 and memory is unchanged.
